// File: rtl/text_menu_pkg.sv
// Shared codes for the text menu: item numbering (also used by the graphics stage),
// file operation codes, navigation FSM encoding and the reset text colour.
package text_menu_pkg;

  localparam logic [2:0] ITEM_OPEN  = 3'd1;
  localparam logic [2:0] ITEM_SAVE  = 3'd2;
  localparam logic [2:0] ITEM_EXIT  = 3'd3;
  localparam logic [2:0] ITEM_CAPS  = 3'd4;
  localparam logic [2:0] ITEM_COLOR = 3'd5;
  localparam logic [2:0] ITEM_SIZE  = 3'd6;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_OPEN = 2'b01;
  localparam logic [1:0] OP_SAVE = 2'b10;
  localparam logic [1:0] OP_EXIT = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [2:0] COLOR_RESET = 3'b111;

  function automatic logic item_valid(input logic [2:0] item);
    return (item != 3'd0) && (item != 3'd7);
  endfunction

  // Circular step through items 1..6.
  function automatic logic [2:0] item_step(input logic [2:0] item, input logic up);
    if (up)
      return (item == ITEM_SIZE) ? ITEM_OPEN : item + 3'd1;
    else
      return (item == ITEM_OPEN) ? ITEM_SIZE : item - 3'd1;
  endfunction

endpackage

// File: rtl/menu_btn_cond.sv
// Push-button conditioning: 2-flop synchronizer, optional debounce (MENU_DEBOUNCE_EN),
// and a registered rising-edge detector that stays disarmed until the button is seen released.
module menu_btn_cond #(
  parameter logic [19:0] DB_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_event
);

  logic       sync1_reg, sync2_reg;
  logic       prev_reg, armed_reg, event_reg;
  logic [1:0] fill_reg;
  logic       stable;

`ifdef MENU_DEBOUNCE_EN
  logic        stable_reg, stable_next;
  logic [19:0] cnt_reg, cnt_next;

  // Stable level flips only after DB_CYCLES consecutive differing samples.
  always_comb begin
    stable_next = stable_reg;
    cnt_next    = '0;
    if (sync2_reg != stable_reg) begin
      if (cnt_reg >= DB_CYCLES - 20'd1)
        stable_next = sync2_reg;
      else
        cnt_next = cnt_reg + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign stable = stable_reg;
`else
  assign stable = sync2_reg;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      fill_reg  <= 2'b00;
      armed_reg <= 1'b0;
      prev_reg  <= 1'b0;
      event_reg <= 1'b0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      fill_reg  <= {fill_reg[0], 1'b1};
      // Arm only once the synchronizer holds real samples showing the button up,
      // so a button held through reset release never yields an event.
      armed_reg <= armed_reg | (fill_reg[1] & ~stable & ~sync2_reg);
      prev_reg  <= stable;
      event_reg <= armed_reg & stable & ~prev_reg;
    end
  end

  assign btn_event = event_reg;

endmodule

// File: rtl/text_menu_nav.sv
// Top-menu navigation: moves the highlighted item, applies caps/colour/size settings and
// runs a four-phase file_req/file_ack handshake. Build macro: MENU_DEBOUNCE_EN.
module text_menu_nav
  import text_menu_pkg::*;
#(
  parameter logic [19:0] DB_CYCLES = 20'd500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       file_ack,
  output logic [2:0] item_selector,
  output logic       file_req,
  output logic [1:0] file_op,
  output logic       caps_on,
  output logic [2:0] color_sel,
  output logic [1:0] size_sel,
  output logic       menu_busy
);

  logic [2:0] btn_raw;
  logic [2:0] btn_ev;

  assign btn_raw = {btn_sel, btn_right, btn_left};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      menu_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_cond (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw[gi]),
        .btn_event(btn_ev[gi])
      );
    end
  endgenerate

  logic [1:0] state_reg, state_next;
  logic [2:0] item_reg, item_next;
  logic       req_reg, req_next;
  logic [1:0] op_reg, op_next;
  logic       caps_reg, caps_next;
  logic [2:0] color_reg, color_next;
  logic [1:0] size_reg, size_next;
  logic       busy_reg;

  always_comb begin
    state_next = state_reg;
    item_next  = item_reg;
    req_next   = req_reg;
    op_next    = op_reg;
    caps_next  = caps_reg;
    color_next = color_reg;
    size_next  = size_reg;
    case (state_reg)
      ST_IDLE: begin
        // Select wins over any coincident move; opposing moves cancel.
        if (btn_ev[2]) begin
          case (item_reg)
            ITEM_OPEN:  begin state_next = ST_REQ; req_next = 1'b1; op_next = OP_OPEN; end
            ITEM_SAVE:  begin state_next = ST_REQ; req_next = 1'b1; op_next = OP_SAVE; end
            ITEM_EXIT:  begin state_next = ST_REQ; req_next = 1'b1; op_next = OP_EXIT; end
            ITEM_CAPS:  caps_next  = ~caps_reg;
            ITEM_COLOR: color_next = color_reg + 3'd1;
            ITEM_SIZE:  size_next  = (size_reg >= 2'd2) ? 2'd0 : size_reg + 2'd1;
            default:    ;
          endcase
        end else if (btn_ev[0] ^ btn_ev[1]) begin
          item_next = item_step(item_reg, btn_ev[1]);
        end
      end
      ST_REQ: begin
        if (file_ack) begin
          state_next = ST_RELEASE;
          req_next   = 1'b0;
        end
      end
      ST_RELEASE: begin
        if (!file_ack) begin
          state_next = ST_IDLE;
          op_next    = OP_NONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        req_next   = 1'b0;
        op_next    = OP_NONE;
      end
    endcase
    if (!item_valid(item_reg))
      item_next = ITEM_OPEN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      item_reg  <= ITEM_OPEN;
      req_reg   <= 1'b0;
      op_reg    <= OP_NONE;
      caps_reg  <= 1'b0;
      color_reg <= COLOR_RESET;
      size_reg  <= 2'd0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      item_reg  <= item_next;
      req_reg   <= req_next;
      op_reg    <= op_next;
      caps_reg  <= caps_next;
      color_reg <= color_next;
      size_reg  <= size_next;
      busy_reg  <= (state_next != ST_IDLE);
    end
  end

  assign item_selector = item_reg;
  assign file_req      = req_reg;
  assign file_op       = op_reg;
  assign caps_on       = caps_reg;
  assign color_sel     = color_reg;
  assign size_sel      = size_reg;
  assign menu_busy     = busy_reg;

endmodule

// File: tb/tb_text_menu_nav.sv
// Scoreboard bench for text_menu_nav: a behavioural menu model pushes expected snapshots,
// which are popped and compared once the DUT has had time to respond.
module tb_text_menu_nav;

`ifdef MENU_DEBOUNCE_EN
  localparam int PRESS = 24;
`else
  localparam int PRESS = 6;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0, file_ack = 1'b0;
  logic [2:0] item_selector, color_sel;
  logic       file_req, caps_on, menu_busy;
  logic [1:0] file_op, size_sel;

  text_menu_nav #(.DB_CYCLES(20'd16)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_sel      (btn_sel),
    .file_ack     (file_ack),
    .item_selector(item_selector),
    .file_req     (file_req),
    .file_op      (file_op),
    .caps_on      (caps_on),
    .color_sel    (color_sel),
    .size_sel     (size_sel),
    .menu_busy    (menu_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] item;
    logic       caps;
    logic [2:0] color;
    logic [1:0] size;
    logic       req;
    logic [1:0] op;
    logic       busy;
  } snap_t;

  snap_t sb_q[$];
  snap_t m;
  int    m_state;  // 0 idle, 1 request, 2 release
  int    checks = 0;
  int    failures = 0;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m       = '{item: 3'd1, caps: 1'b0, color: 3'b111, size: 2'd0, req: 1'b0, op: 2'b00, busy: 1'b0};
    m_state = 0;
  endtask

  task automatic sb_pop_check(input string tag);
    snap_t e;
    e = sb_q.pop_front();
    check_val({tag, ".item"},  8'(item_selector), 8'(e.item));
    check_val({tag, ".caps"},  8'(caps_on),       8'(e.caps));
    check_val({tag, ".color"}, 8'(color_sel),     8'(e.color));
    check_val({tag, ".size"},  8'(size_sel),      8'(e.size));
    check_val({tag, ".req"},   8'(file_req),      8'(e.req));
    check_val({tag, ".op"},    8'(file_op),       8'(e.op));
    check_val({tag, ".busy"},  8'(menu_busy),     8'(e.busy));
    $display("txn %-14s item=%0d caps=%0d color=%03b size=%0d req=%0d op=%02b busy=%0d",
             tag, item_selector, caps_on, color_sel, size_sel, file_req, file_op, menu_busy);
  endtask

  task automatic model_press(input logic l, input logic r, input logic s);
    if (m_state != 0) return;
    if (s) begin
      case (m.item)
        3'd1: begin m.req = 1'b1; m.op = 2'b01; m.busy = 1'b1; m_state = 1; end
        3'd2: begin m.req = 1'b1; m.op = 2'b10; m.busy = 1'b1; m_state = 1; end
        3'd3: begin m.req = 1'b1; m.op = 2'b11; m.busy = 1'b1; m_state = 1; end
        3'd4: m.caps = ~m.caps;
        3'd5: m.color = m.color + 3'd1;
        3'd6: m.size = (m.size == 2'd2) ? 2'd0 : m.size + 2'd1;
        default: ;
      endcase
    end else if (l && !r) begin
      m.item = (m.item == 3'd1) ? 3'd6 : m.item - 3'd1;
    end else if (r && !l) begin
      m.item = (m.item == 3'd6) ? 3'd1 : m.item + 3'd1;
    end
  endtask

  task automatic press(input logic l, input logic r, input logic s, input string tag);
    model_press(l, r, s);
    sb_q.push_back(m);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_sel = s;
    repeat (PRESS) @(negedge clk);
    btn_left = 1'b0; btn_right = 1'b0; btn_sel = 1'b0;
    repeat (PRESS) @(negedge clk);
    sb_pop_check(tag);
  endtask

  // Drive file_ack at a negedge and sample one rising edge later.
  task automatic ack_step(input logic val, input string tag);
    if (m_state == 1 && val) begin m_state = 2; m.req = 1'b0; end
    else if (m_state == 2 && !val) begin m_state = 0; m.op = 2'b00; m.busy = 1'b0; end
    sb_q.push_back(m);
    @(negedge clk);
    file_ack = val;
    @(negedge clk);
    sb_pop_check(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    sb_q.push_back(m);
    #1 sb_pop_check(tag);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    sb_q.push_back(m);
    sb_pop_check("reset");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) press(1'b0, 1'b1, 1'b0, $sformatf("right%0d", i));
    press(1'b1, 1'b0, 1'b0, "left_wrap");
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0, $sformatf("to3_%0d", i));
    press(1'b1, 1'b1, 1'b0, "left_right");
    press(1'b0, 1'b1, 1'b0, "to_caps");
    press(1'b0, 1'b1, 1'b1, "sel_right");
    press(1'b0, 1'b1, 1'b0, "to_color");
    for (int i = 0; i < 8; i++) press(1'b0, 1'b0, 1'b1, $sformatf("color%0d", i));
    press(1'b0, 1'b1, 1'b0, "to_size");
    for (int i = 0; i < 3; i++) press(1'b0, 1'b0, 1'b1, $sformatf("size%0d", i));
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0, $sformatf("to_save%0d", i));

    // Acknowledge in IDLE is ignored.
    ack_step(1'b1, "idle_ack_hi");
    ack_step(1'b0, "idle_ack_lo");

    press(1'b0, 1'b0, 1'b1, "save_req");
    press(1'b0, 1'b1, 1'b0, "req_right");
    press(1'b0, 1'b0, 1'b1, "req_sel");
    ack_step(1'b1, "ack_hi");
    press(1'b1, 1'b0, 1'b0, "rel_left");
    ack_step(1'b0, "ack_lo");

    press(1'b1, 1'b0, 1'b0, "to_open");
    press(1'b0, 1'b0, 1'b1, "open_req");
    async_reset("reset_in_req");

    // Select held across reset release must not fire.
    btn_sel = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sb_q.push_back(m);
    repeat (3 * PRESS) @(negedge clk);
    btn_sel = 1'b0;
    repeat (2 * PRESS) @(negedge clk);
    sb_pop_check("held_sel");
    press(1'b0, 1'b0, 1'b1, "open_again");
    ack_step(1'b1, "open_ack_hi");
    ack_step(1'b0, "open_ack_lo");

`ifdef MENU_DEBOUNCE_EN
    sb_q.push_back(m);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk); btn_right = 1'b1;
      repeat (10) @(negedge clk); btn_right = 1'b0;
      repeat (10) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    sb_pop_check("db_glitch");
    model_press(1'b0, 1'b1, 1'b0);
    sb_q.push_back(m);
    @(negedge clk); btn_right = 1'b1;
    repeat (20) @(negedge clk); btn_right = 1'b0;
    repeat (40) @(negedge clk);
    sb_pop_check("db_hold");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_menu_nav.md
TEXT_MENU_NAV -- requirements
Module: text_menu_nav

Interface
REQ-001 Parameter DB_CYCLES, default 20'd500000, number of stable clk cycles required to accept a button level (10 ms at 50 MHz).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 btn_left, btn_right, btn_sel  input  1 each  raw, asynchronous, active-high push-button levels.
REQ-005 file_ack  input  1  file-engine acknowledge, four-phase handshake partner of file_req.
REQ-006 item_selector  output  3  highlighted top-menu item, encoded 1..6 (1 open, 2 save, 3 exit, 4 caps, 5 color, 6 size), drives the menu graphics stage.
REQ-007 file_req  output  1  file operation request.
REQ-008 file_op  output  2  operation code, valid while file_req high: 01 open, 10 save, 11 exit.
REQ-009 caps_on  output  1  caps-lock state; color_sel  output  3  text RGB; size_sel  output  2  font size index.
REQ-010 menu_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 Each button SHALL pass a 2-flop synchronizer, then conditioning (REQ-030/031), then a rising-edge detector producing a 1-cycle event.
REQ-012 right event in IDLE SHALL increment item_selector, 6 wrapping to 1; left event SHALL decrement, 1 wrapping to 6.
REQ-013 left and right events in the same cycle SHALL cancel: item_selector unchanged.
REQ-014 sel event SHALL take priority over a coincident left/right event; no move occurs that cycle.
REQ-015 sel in IDLE with item 4 SHALL toggle caps_on the next cycle.
REQ-016 sel with item 5 SHALL increment color_sel modulo 8 (3'b111 -> 3'b000).
REQ-017 sel with item 6 SHALL increment size_sel modulo 3 (0,1,2,0).
REQ-018 sel with item 1, 2 or 3 SHALL move FSM IDLE -> REQ and, on that same edge, set file_op per REQ-008 and assert file_req.
REQ-019 FSM states: IDLE, REQ, RELEASE; encoded in 2 bits.
REQ-020 REQ: file_req held high, file_op stable; on file_ack=1 go to RELEASE and drop file_req the next cycle.
REQ-021 RELEASE: file_req low; on file_ack=0 return to IDLE; file_op cleared to 00 on that transition.
REQ-022 In REQ and RELEASE all button events SHALL be discarded, not queued; item_selector, caps_on, color_sel, size_sel frozen.
REQ-023 file_ack high while IDLE SHALL be ignored.
REQ-024 menu_busy SHALL equal (state != IDLE), registered, no combinational path from inputs to any output.
REQ-025 item_selector SHALL never hold 0 or 7; if ever corrupted to either it SHALL be forced to 1 on the next cycle.

Reset
REQ-026 Reset low SHALL immediately force: item_selector 3'd1, file_req 0, file_op 00, caps_on 0, color_sel 3'b111, size_sel 0, menu_busy 0, FSM IDLE, synchronizer/debounce/edge registers 0.
REQ-027 Reset asserted mid-handshake SHALL abandon the request; file_req low asynchronously.
REQ-028 A button held through reset release SHALL NOT produce an event until released and pressed again.

Configuration
REQ-029 Macro MENU_DEBOUNCE_EN selects button conditioning.
REQ-030 Defined: each synchronized button feeds a counter; stable level is updated only after DB_CYCLES consecutive cycles of a differing input; counter clears on any bounce.
REQ-031 Undefined: stable level equals synchronizer output; DB_CYCLES unused; event latency 3 cycles from input edge.

Structure
REQ-032 Shared package text_menu_pkg SHALL hold item codes 1..6, file_op codes, FSM state encoding and reset color 3'b111; the graphics stage uses the same item codes.
REQ-033 One sub-module, menu_btn_cond (synchronizer + optional debounce + edge detect), instantiated three times.

Verification
REQ-034 Reset, 5 right presses -> item_selector 1,2,3,4,5,6 then sixth press -> 1; left press at 1 -> 6.
REQ-035 Left and right rising together at item 3 -> item stays 3; sel + right together at item 4 -> caps_on 1, item 4.
REQ-036 Item 2, sel -> file_req 1, file_op 10, menu_busy 1; right presses during REQ ignored; file_ack 1 -> file_req 0 next cycle; file_ack 0 -> IDLE, file_op 00, item still 2.
REQ-037 Item 5, 8 sel presses -> color_sel 111,000,...,111; item 6, 3 presses -> size_sel 1,2,0.
REQ-038 With MENU_DEBOUNCE_EN, DB_CYCLES=16: btn_right glitches of 10 cycles -> no move; 20-cycle hold -> one move.
REQ-039 Reset low during REQ -> all outputs to REQ-026 values asynchronously; held btn_sel across release -> no event.
